nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//   Sequential front-end/back-end wrapper around the team's 4-bit CLA slice (module CLA).
//   Accepts a WIDTH-bit operand pair over a valid/ready handshake.
//   Feeds one nibble per clock into a single CLA instance, least-significant nibble first, and chains c4 -> c0 through a carry register.
//   Assembles the WIDTH-bit sum and final carry, then presents them on a valid/ready output handshake.
//   This lets one CLA slice serve arbitrary-width adds in the datapath.
// PARAMETERS
//   WIDTH  16  operand/sum width in bits; must be a multiple of 4 and >= 8
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand pair a/b/cin valid
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in to nibble 0
//   out_valid  out  1      sum/cout/zero valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  registered sum
//   cout       out  1      carry out of the top nibble
//   zero       out  1      high when sum == 0
// BEHAVIOUR
//   - FSM states: IDLE, RUN, DONE.
//     - IDLE -> RUN on in_valid & in_ready. Latch a, b into shift registers, cin into carry_q, nib_idx <= 0.
//     - RUN: each edge captures CLA s[3:0] into sum nibble nib_idx, sets carry_q <= c4, and increments nib_idx.
//     - RUN -> DONE on the edge that captures nibble WIDTH/4-1.
//     - DONE -> IDLE on out_valid & out_ready.
//   - Latency: out_valid rises exactly WIDTH/4 edges after the accepting edge (WIDTH=16: 4 edges).
//   - Throughput: one result per WIDTH/4+2 cycles. No overlap; in_ready=0 in RUN and DONE.
//   - CLA drive: a0..a3/b0..b3 come from the current operand nibble and c0 from carry_q.
//     - Slice outputs p4/g4_inv are unused.
//     - The CLA path is combinational within one cycle.
//   - In DONE, sum/cout/zero are held stable while out_ready=0. Backpressure is unbounded.
//   - in_valid while not IDLE is ignored; operands are not sampled.
//   - a/b changes after the accepting edge have no effect (operands are latched).
//   - cout = carry_q after the final nibble. zero = (sum == 0), registered with sum.
//   - Arithmetic is modulo 2^WIDTH; the carry out of the top nibble appears only on cout.
//   - Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, zero=0, carry_q=0, nib_idx=0.
//   - Reset in any state (including mid-RUN or DONE) aborts the operation in the same edge.
//     - The partial result is discarded; no out_valid follows.
//   - rst has priority over every handshake in the same cycle.
// CONFIGURATION
//   ADDSUB_EN defined:
//     - Adds input port `sub` (1 bit), latched at accept.
//     - When sub=1: b is inverted nibble-wise before the CLA and the initial carry_q is forced to 1 (cin ignored).
//     - The result is a - b; cout=1 means no borrow.
//     - When sub=0: identical to plain add.
//   ADDSUB_EN undefined:
//     - No `sub` port; add only. cin is always used.
// TESTING (WIDTH=16 unless noted)
//   1. a=0x1234, b=0x4321, cin=0 -> 4 edges after accept: sum=0x5555, cout=0, zero=0, out_valid=1.
//   2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, zero=1. Carry ripples through all 4 nibbles.
//   3. Result with out_ready=0 for 10 cycles, then 1
//      -> sum/cout held stable and in_ready=0 throughout; out_valid drops and in_ready rises the edge after out_ready=1.
//   4. rst=1 on the 2nd RUN edge of a=0x0F0F, b=0x0101
//      -> next cycle state IDLE, in_ready=1, sum=0, out_valid=0; no result emitted.
//   5. a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
//      WIDTH=8: a=0x80, b=0x80 -> sum=0x00, cout=1, latency 2 edges.
//   6. ADDSUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0.
//      a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder reusing one 4-bit CLA slice over a valid/ready handshake.
// Optional subtract mode under `ADDSUB_EN (adds port sub; result a - b, cout=1 means no borrow).
module CLA (
  input  logic       a0,
  input  logic       a1,
  input  logic       a2,
  input  logic       a3,
  input  logic       b0,
  input  logic       b1,
  input  logic       b2,
  input  logic       b3,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4,
  output logic       p4,
  output logic       g4_inv
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;
  logic       gg;

  assign p = {a3 ^ b3, a2 ^ b2, a1 ^ b1, a0 ^ b0};
  assign g = {a3 & b3, a2 & b2, a1 & b1, a0 & b0};

  assign c[0] = c0;
  assign c[1] = g[0] | (p[0] & c0);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);

  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);

  assign p4     = &p;
  assign g4_inv = ~gg;
  assign c4     = gg | (p4 & c0);
  assign s      = p ^ c;
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDSUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zero
);
  localparam int NIB = WIDTH / 4;
  localparam int NW  = $clog2(NIB);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry_q;
  logic [NW-1:0]    nib_idx;
  logic [3:0]       s;
  logic             c4;
  logic             p4_unused;
  logic             g4_inv_unused;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             last;

`ifdef ADDSUB_EN
  // Subtract as a + ~b + 1: invert b once at accept, force carry-in.
  assign b_in = sub ? ~b : b;
  assign c_in = sub | cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  // Nibbles shift in from the top so nibble 0 lands at bit 0 after NIB steps.
  assign sum_next = {s, sum[WIDTH-1:4]};
  assign last     = (nib_idx == NW'(NIB - 1));

  CLA u_cla (
    .a0     (a_sh[0]),
    .a1     (a_sh[1]),
    .a2     (a_sh[2]),
    .a3     (a_sh[3]),
    .b0     (b_sh[0]),
    .b1     (b_sh[1]),
    .b2     (b_sh[2]),
    .b3     (b_sh[3]),
    .c0     (carry_q),
    .s      (s),
    .c4     (c4),
    .p4     (p4_unused),
    .g4_inv (g4_inv_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      carry_q   <= 1'b0;
      nib_idx   <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= a;
            b_sh     <= b_in;
            carry_q  <= c_in;
            nib_idx  <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 4;
          b_sh    <= b_sh >> 4;
          sum     <= sum_next;
          carry_q <= c4;
          nib_idx <= nib_idx + 1'b1;
          if (last) begin
            nib_idx   <= '0;
            cout      <= c4;
            zero      <= (sum_next == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed checks of nibble_serial_adder against an arithmetic model.
// Covers WIDTH=16 and a WIDTH=8 instance.
module tb_nibble_serial_adder;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         zero;
  logic         sub;

  logic         in_valid8;
  logic         in_ready8;
  logic [7:0]   a8;
  logic [7:0]   b8;
  logic         cin8;
  logic         out_valid8;
  logic         out_ready8;
  logic [7:0]   sum8;
  logic         cout8;
  logic         zero8;
  logic         sub8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADDSUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .zero      (zero)
  );

  nibble_serial_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
`ifdef ADDSUB_EN
    .sub       (sub8),
`endif
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8),
    .zero      (zero8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns {cout, sum}: add is a+b+cin, subtract is a-b with cout = no borrow.
  function automatic logic [W:0] model(input logic [W-1:0] x,
                                       input logic [W-1:0] y,
                                       input logic ci,
                                       input logic sb);
    logic [W-1:0] d;
    if (sb) begin
      d = x - y;
      return {(x >= y), d};
    end
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic sb,
                        output logic [W-1:0] s, output logic co,
                        output logic z, output int lat,
                        output logic ov_after, output logic ir_after);
    a = x;
    b = y;
    cin = ci;
    sub = sb;
    out_ready = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    s = sum;
    co = cout;
    z = zero;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    ov_after = out_valid;
    ir_after = in_ready;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    total++;
    if (sum !== '0 || cout !== 1'b0 || zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_result got=%h/%b/%b want=0/0/0",
               sum, cout, zero);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic         vc [3];
    logic [W-1:0] s;
    logic [W:0]   exp;
    logic         co, z, ov, ir;
    int           lat;
    va = '{16'h1234, 16'hFFFF, 16'h0000};
    vb = '{16'h4321, 16'h0001, 16'h0000};
    vc = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      exp = model(va[i], vb[i], vc[i], 1'b0);
      run_op(va[i], vb[i], vc[i], 1'b0, s, co, z, lat, ov, ir);
      total++;
      if ({co, s} !== exp) begin
        bad++;
        $display("FAIL directed%0d_sum got=%b/%h want=%b/%h",
                 i, co, s, exp[W], exp[W-1:0]);
      end
      total++;
      if (z !== (exp[W-1:0] == '0)) begin
        bad++;
        $display("FAIL directed%0d_zero got=%b", i, z);
      end
      total++;
      if (lat !== NIB) begin
        bad++;
        $display("FAIL directed%0d_latency got=%0d want=%0d", i, lat, NIB);
      end
      total++;
      if (ov !== 1'b0 || ir !== 1'b1) begin
        bad++;
        $display("FAIL directed%0d_release got=%b/%b want=0/1", i, ov, ir);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [W:0] exp;
    int         lat;
    exp = model(16'hA5A5, 16'h1111, 1'b1, 1'b0);
    a = 16'hA5A5;
    b = 16'h1111;
    cin = 1'b1;
    sub = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    tick();
    lat = 0;
    while (!out_valid && lat < 20) begin
      a = W'($urandom);
      tick();
      lat++;
    end
    total++;
    if (lat !== NIB) begin
      bad++;
      $display("FAIL bp_latency got=%0d want=%0d", lat, NIB);
    end
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      tick();
      total++;
      if ({cout, sum} !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d got=%b/%h v=%b r=%b want=%b/%h v=1 r=0",
                 i, cout, sum, out_valid, in_ready, exp[W], exp[W-1:0]);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release got=%b/%b want=0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    int seen;
    a = 16'h0F0F;
    b = 16'h0101;
    cin = 1'b0;
    sub = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0) begin
      bad++;
      $display("FAIL abort_state got r=%b v=%b s=%h want r=1 v=0 s=0",
               in_ready, out_valid, sum);
    end
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort_no_result got=%0d valid cycles want=0", seen);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] x, y, s;
    logic [W:0]   exp;
    logic         ci, sb, co, z, ov, ir;
    int           lat;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom);
      y = (i % 8 == 0) ? (~x + 16'(i % 2)) : W'($urandom);
      ci = 1'($urandom);
`ifdef ADDSUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      exp = model(x, y, ci, sb);
      run_op(x, y, ci, sb, s, co, z, lat, ov, ir);
      total++;
      if ({co, s} !== exp || z !== (exp[W-1:0] == '0) || lat !== NIB) begin
        bad++;
        $display("FAIL rand%0d a=%h b=%h ci=%b sb=%b got=%b/%h z=%b lat=%0d want=%b/%h lat=%0d",
                 i, x, y, ci, sb, co, s, z, lat, exp[W], exp[W-1:0], NIB);
      end
    end
  endtask

`ifdef ADDSUB_EN
  task automatic test_sub;
    logic [W-1:0] s;
    logic         co, z, ov, ir;
    int           lat;
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, s, co, z, lat, ov, ir);
    total++;
    if (s !== 16'hFFFE || co !== 1'b0) begin
      bad++;
      $display("FAIL sub_borrow got=%b/%h want=0/fffe", co, s);
    end
    run_op(16'h0007, 16'h0005, 1'b1, 1'b1, s, co, z, lat, ov, ir);
    total++;
    if (s !== 16'h0002 || co !== 1'b1) begin
      bad++;
      $display("FAIL sub_noborrow got=%b/%h want=1/0002", co, s);
    end
  endtask
`endif

  task automatic test_width8;
    logic [7:0] x, y;
    logic [8:0] exp;
    logic       ci;
    int         lat;
    out_ready8 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x = (i == 0) ? 8'h80 : 8'($urandom);
      y = (i == 0) ? 8'h80 : 8'($urandom);
      ci = (i == 0) ? 1'b0 : 1'($urandom);
      exp = {1'b0, x} + {1'b0, y} + {8'b0, ci};
      a8 = x;
      b8 = y;
      cin8 = ci;
      sub8 = 1'b0;
      in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      lat = 0;
      while (!out_valid8 && lat < 20) begin
        tick();
        lat++;
      end
      total++;
      if ({cout8, sum8} !== exp || zero8 !== (exp[7:0] == 8'h00) || lat !== 2) begin
        bad++;
        $display("FAIL w8_%0d a=%h b=%h got=%b/%h z=%b lat=%0d want=%b/%h lat=2",
                 i, x, y, cout8, sum8, zero8, lat, exp[8], exp[7:0]);
      end
      tick();
    end
    out_ready8 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    out_ready = 1'b0;
    in_valid8 = 1'b0;
    a8 = '0;
    b8 = '0;
    cin8 = 1'b0;
    sub8 = 1'b0;
    out_ready8 = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
`ifdef ADDSUB_EN
    test_sub();
`endif
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
